// File: rtl/wrr_arbiter_pkg.sv
// wrr_arbiter_pkg: definitions shared by the weighted round-robin arbiter
// and its round-robin pick helper.
//   state_t  : arbiter FSM state encoding (idle / granting)
//   wrr_iw() : grant-index width for a given requester count
package wrr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int wrr_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Finds the first set bit of req, starting at ptr and wrapping modulo N.
//   req    [N]  : request vector
//   ptr    [IW] : highest-priority index for this search (must be < N)
//   found       : any request present
//   idx    [IW] : index of the selected requester (0 when !found)
//   onehot [N]  : one-hot form of idx (all zero when !found)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;

    // The low copy keeps only bits at or above ptr; the high copy holds the
    // full vector, so the lowest set bit of the concatenation is the first
    // requester at or after ptr in wrap-around order.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_mask[i] = (i >= 32'(ptr));
        end
        w_dbl = {req, req & w_mask};
    end

    always_comb begin
        int unsigned v_pos;
        v_pos = 0;
        found = |req;
        for (int unsigned j = 2 * N; j > 0; j--) begin
            if (w_dbl[j-1]) begin
                v_pos = j - 1;
            end
        end
        if (v_pos >= N) begin
            v_pos = v_pos - N;
        end
        idx    = IW'(v_pos);
        onehot = found ? (N'(1) << v_pos) : '0;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered outputs.
// Each winner may hold the grant for up to its programmed weight of
// consecutive cycles (weight 0 behaves as 1) before priority rotates.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   req     [N]    : request vector, bit i = requester i
//   weight  [N*WW] : per-requester weights, [i*WW +: WW] = requester i
//   gnt     [N]    : one-hot grant
//   gnt_vld        : any grant active
//   gnt_id  [IW]   : index of granted requester
//   last           : final cycle of the current hold
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = wrr_iw(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_id,
    output logic            last
);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [WW-1:0] r_credit;
    logic [N-1:0]  r_gnt;
    logic          r_gnt_vld;
    logic [IW-1:0] r_gnt_id;
    logic          r_last;

    logic [IW-1:0] w_next_ptr;
    logic [IW-1:0] w_pick_ptr;
    logic          w_found;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_onehot;
    logic [WW-1:0] w_new_w;
    logic [WW-1:0] w_fresh_credit;
    logic          w_fresh_last;
    logic          w_hold;

    // Priority pointer after releasing the current owner.
    assign w_next_ptr = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + IW'(1);

    // On release the search starts past the old owner in the same edge,
    // so handover needs no idle bubble.
    assign w_pick_ptr = (r_state == ST_GRANT) ? w_next_ptr : r_ptr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (w_pick_ptr),
        .found  (w_found),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    assign w_new_w        = weight[32'(w_idx) * WW +: WW];
    assign w_fresh_credit = (w_new_w == '0) ? '0 : w_new_w - WW'(1);
    assign w_fresh_last   = (w_new_w <= WW'(1));
    assign w_hold         = req[r_gnt_id] && (r_credit != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_credit  <= '0;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= '0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state   <= ST_GRANT;
                        r_gnt     <= w_onehot;
                        r_gnt_vld <= 1'b1;
                        r_gnt_id  <= w_idx;
                        r_credit  <= w_fresh_credit;
                        r_last    <= w_fresh_last;
                    end
                end
                ST_GRANT: begin
                    if (w_hold) begin
                        r_credit <= r_credit - WW'(1);
                        r_last   <= (r_credit == WW'(1));
                    end else begin
                        // Remaining credit is discarded on release.
                        r_ptr <= w_next_ptr;
                        if (w_found) begin
                            r_gnt     <= w_onehot;
                            r_gnt_vld <= 1'b1;
                            r_gnt_id  <= w_idx;
                            r_credit  <= w_fresh_credit;
                            r_last    <= w_fresh_last;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_gnt     <= '0;
                            r_gnt_vld <= 1'b0;
                            r_gnt_id  <= '0;
                            r_credit  <= '0;
                            r_last    <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign gnt_id  = r_gnt_id;
    assign last    = r_last;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed self-checking bench for wrr_arbiter (N=4, WW=4).
module tb_wrr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic        last;

    int errors;
    int checks;

    wrr_arbiter #(
        .N  (4),
        .WW (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .weight  (weight),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .last    (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] eg,
                       input logic [1:0] eid, input logic el);
        checks++;
        assert (gnt === eg) else begin
            errors++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        checks++;
        assert (gnt_vld === (|eg)) else begin
            errors++;
            $error("FAIL %s gnt_vld got=%b exp=%b", tag, gnt_vld, |eg);
        end
        if (eg != 4'b0000) begin
            checks++;
            assert (gnt_id === eid) else begin
                errors++;
                $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, eid);
            end
        end
        checks++;
        assert (last === el) else begin
            errors++;
            $error("FAIL %s last got=%b exp=%b", tag, last, el);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v_g;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        weight = 16'h1111;

        // Reset state and idle with no requests
        do_reset();
        checks++;
        assert (gnt_id === 2'd0) else begin
            errors++;
            $error("FAIL rst_id gnt_id got=%0d exp=0", gnt_id);
        end
        chk("rst", 4'b0000, 2'd0, 1'b0);
        step();
        chk("idle", 4'b0000, 2'd0, 1'b0);

        // 1: all weights 1, full request -> plain rotation, last every cycle
        do_reset();
        weight = 16'h1111;
        req    = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            v_g = 4'b0001 << (k % 4);
            chk($sformatf("t1_c%0d", k), v_g, 2'(k % 4), 1'b1);
        end

        // 2: weight0=3, req 0011 -> 0,0,0(last),1(last),0,0,0(last)
        do_reset();
        weight = 16'h1113;
        req    = 4'b0011;
        step(); chk("t2_c1", 4'b0001, 2'd0, 1'b0);
        step(); chk("t2_c2", 4'b0001, 2'd0, 1'b0);
        step(); chk("t2_c3", 4'b0001, 2'd0, 1'b1);
        step(); chk("t2_c4", 4'b0010, 2'd1, 1'b1);
        step(); chk("t2_c5", 4'b0001, 2'd0, 1'b0);
        step(); chk("t2_c6", 4'b0001, 2'd0, 1'b0);
        step(); chk("t2_c7", 4'b0001, 2'd0, 1'b1);

        // 3: sole requester 2 with weight 2 -> continuous grant, last on even cycles
        do_reset();
        weight = 16'h1211;
        req    = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("t3_c%0d", k), 4'b0100, 2'd2, (k % 2) == 0);
        end

        // 4: early drop of req1 (weight 5) hands over to 3 without a bubble
        do_reset();
        weight = 16'h1151;
        req    = 4'b1010;
        step(); chk("t4_c1", 4'b0010, 2'd1, 1'b0);
        step(); chk("t4_c2", 4'b0010, 2'd1, 1'b0);
        req = 4'b1000;
        step(); chk("t4_c3", 4'b1000, 2'd3, 1'b1);
        req = 4'b1111;
        step(); chk("t4_wrap", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        step(); chk("t4_idle", 4'b0000, 2'd0, 1'b0);

        // 5: weight 0 behaves as 1
        do_reset();
        weight = 16'h0111;
        req    = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("t5_c%0d", k), 4'b1000, 2'd3, 1'b1);
        end

        // 6: asynchronous reset mid-hold, then restart from requester 0
        do_reset();
        weight = 16'h1151;
        req    = 4'b0010;
        step(); chk("t6_hold", 4'b0010, 2'd1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        assert (gnt_id === 2'd0) else begin
            errors++;
            $error("FAIL t6_async_id gnt_id got=%0d exp=0", gnt_id);
        end
        chk("t6_async", 4'b0000, 2'd0, 1'b0);
        #2;
        rst = 1'b0;
        req = 4'b1111;
        step(); chk("t6_first", 4'b0001, 2'd0, 1'b1);
        step(); chk("t6_next", 4'b0010, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
